// File: rtl/instruction_fetch_unit_pkg.sv
// ---------------------------------------------------------------------------
// instruction_fetch_unit_pkg
// Shared CPU definitions used by the fetch unit and its decode-side FIFO:
//   WORD_W        - architectural word width (32)
//   ENTRY_W       - width of one {pc, instruction} FIFO entry
//   NOP_INSTR     - RV32 canonical NOP (addi x0,x0,0)
//   fetch_state_e - fetch FSM state encoding (BOOT / RUN / HALT)
//   fetch_entry_t - packed {pc, instr} pair carried to decode
//   addr_out_of_range() - word-index bounds check against memory depth
// ---------------------------------------------------------------------------
package instruction_fetch_unit_pkg;

  localparam int WORD_W  = 32;
  localparam int ENTRY_W = 2 * WORD_W;

  localparam logic [WORD_W-1:0] NOP_INSTR = 32'h00000013;

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [WORD_W-1:0] pc;
    logic [WORD_W-1:0] instr;
  } fetch_entry_t;

  // True when the word index of addr lies at or beyond the memory depth.
  function automatic logic addr_out_of_range(input logic [WORD_W-1:0] addr,
                                             input logic [WORD_W-1:0] words);
    return ({2'b00, addr[WORD_W-1:2]} >= words);
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// ---------------------------------------------------------------------------
// fetch_fifo
// Two-entry FIFO holding {pc, instruction} pairs between fetch and decode.
// Ports:
//   clk   - clock, all updates on rising edge
//   reset - synchronous active-high reset (empties the FIFO)
//   clear - synchronous flush (empties the FIFO, overrides push/pop)
//   push  - write din; accepted when not full or when popping this cycle
//   pop   - drop the head entry; ignored when empty
//   din   - entry to write
//   dout  - current head entry (meaningful only when count != 0)
//   count - number of valid entries (0..2)
// ---------------------------------------------------------------------------
module fetch_fifo
  import instruction_fetch_unit_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               clear,
  input  logic               push,
  input  logic               pop,
  input  logic [ENTRY_W-1:0] din,
  output logic [ENTRY_W-1:0] dout,
  output logic [1:0]         count
);

  logic [ENTRY_W-1:0] r_head;
  logic [ENTRY_W-1:0] r_tail;
  logic [1:0]         r_count;
  logic               w_pop_ok;
  logic               w_push_ok;

  assign w_pop_ok  = pop && (r_count != 2'd0);
  assign w_push_ok = push && ((r_count != 2'd2) || w_pop_ok);

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      r_count <= 2'd0;
    end else begin
      unique case ({w_push_ok, w_pop_ok})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage is not reset: r_count alone decides what is valid. The head is
  // always slot r_head, so a pop with two entries shifts the tail forward.
  always_ff @(posedge clk) begin
    unique case (r_count)
      2'd0: begin
        if (w_push_ok) r_head <= din;
      end
      2'd1: begin
        if (w_push_ok && w_pop_ok) r_head <= din;
        else if (w_push_ok)        r_tail <= din;
      end
      2'd2: begin
        if (w_pop_ok) begin
          r_head <= r_tail;
          if (w_push_ok) r_tail <= din;
        end
      end
      default: begin
        r_head <= r_head;
      end
    endcase
  end

  assign dout  = r_head;
  assign count = r_count;

endmodule

// File: rtl/instruction_fetch_unit.sv
// ---------------------------------------------------------------------------
// instruction_fetch_unit
// Sequential instruction fetch with redirect, decode backpressure through a
// two-entry FIFO, and a sticky fault on misaligned / out-of-range addresses.
// Parameters:
//   RESET_PC   - first fetch address after reset
//   IMEM_WORDS - instruction memory depth in 32-bit words
//   NOP_INSTR  - word presented on id_instr when nothing is valid
// Ports:
//   clk, reset       - clock and synchronous active-high reset
//   pc               - fetch address to instruction memory (registered)
//   instruction      - combinational memory read data for pc
//   redirect_valid   - taken branch/jump resolved this cycle
//   redirect_target  - new fetch address
//   id_valid/id_ready- decode handshake; id_pc/id_instr carry the FIFO head
//   fetch_fault      - sticky fault flag
//   fault_pc         - address that caused the fault
// ---------------------------------------------------------------------------
module instruction_fetch_unit
  import instruction_fetch_unit_pkg::*;
#(
  parameter logic [WORD_W-1:0] RESET_PC   = 32'h00000000,
  parameter int                IMEM_WORDS = 1024,
  parameter logic [WORD_W-1:0] NOP_INSTR  = instruction_fetch_unit_pkg::NOP_INSTR
) (
  input  logic              clk,
  input  logic              reset,
  output logic [WORD_W-1:0] pc,
  input  logic [WORD_W-1:0] instruction,
  input  logic              redirect_valid,
  input  logic [WORD_W-1:0] redirect_target,
  output logic              id_valid,
  input  logic              id_ready,
  output logic [WORD_W-1:0] id_pc,
  output logic [WORD_W-1:0] id_instr,
  output logic              fetch_fault,
  output logic [WORD_W-1:0] fault_pc
);

  localparam logic [WORD_W-1:0] IMEM_LIMIT = 32'(IMEM_WORDS);

  fetch_state_e      r_state;
  fetch_state_e      w_state_nxt;
  logic [WORD_W-1:0] r_pc;
  logic [WORD_W-1:0] w_pc_nxt;
  logic              r_fault;
  logic [WORD_W-1:0] r_fault_pc;
  logic              w_fault_set;
  logic [WORD_W-1:0] w_fault_addr;

  logic              w_push;
  logic              w_pop;
  logic              w_clear;
  logic [1:0]        w_count;
  logic              w_full;
  logic              w_valid;
  logic              w_target_bad;
  logic              w_pc_bad;
  fetch_entry_t      w_din;
  fetch_entry_t      w_head;

  assign w_valid      = (w_count != 2'd0);
  assign w_full       = (w_count == 2'd2);
  assign w_pop        = w_valid && id_ready;
  assign w_target_bad = (redirect_target[1:0] != 2'b00) ||
                        addr_out_of_range(redirect_target, IMEM_LIMIT);
  assign w_pc_bad     = addr_out_of_range(r_pc, IMEM_LIMIT);

  assign w_din.pc    = r_pc;
  assign w_din.instr = instruction;

  fetch_fifo u_fetch_fifo (
    .clk   (clk),
    .reset (reset),
    .clear (w_clear),
    .push  (w_push),
    .pop   (w_pop),
    .din   (w_din),
    .dout  (w_head),
    .count (w_count)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_BOOT;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Redirect outranks sequential fetch; a same-cycle pop is harmless since
  // the FIFO clear wins inside fetch_fifo.
  always_comb begin
    w_state_nxt  = r_state;
    w_pc_nxt     = r_pc;
    w_push       = 1'b0;
    w_clear      = 1'b0;
    w_fault_set  = 1'b0;
    w_fault_addr = r_fault_pc;
    unique case (r_state)
      ST_BOOT: begin
        w_state_nxt = ST_RUN;
      end
      ST_RUN: begin
        if (redirect_valid) begin
          w_clear = 1'b1;
          if (w_target_bad) begin
            w_state_nxt  = ST_HALT;
            w_fault_set  = 1'b1;
            w_fault_addr = redirect_target;
          end else begin
            w_pc_nxt = redirect_target;
          end
        end else if (w_pc_bad) begin
          w_clear      = 1'b1;
          w_state_nxt  = ST_HALT;
          w_fault_set  = 1'b1;
          w_fault_addr = r_pc;
        end else if (!w_full || w_pop) begin
          w_push   = 1'b1;
          w_pc_nxt = r_pc + 32'd4;
        end
      end
      ST_HALT: begin
        w_state_nxt = ST_HALT;
      end
      default: begin
        w_state_nxt = ST_BOOT;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_pc       <= RESET_PC;
      r_fault    <= 1'b0;
      r_fault_pc <= '0;
    end else begin
      r_pc <= w_pc_nxt;
      if (w_fault_set) begin
        r_fault    <= 1'b1;
        r_fault_pc <= w_fault_addr;
      end
    end
  end

  assign pc          = r_pc;
  assign id_valid    = w_valid;
  assign id_pc       = w_valid ? w_head.pc : '0;
  assign id_instr    = w_valid ? w_head.instr : NOP_INSTR;
  assign fetch_fault = r_fault;
  assign fault_pc    = r_fault_pc;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
module tb_instruction_fetch_unit;

  localparam logic [31:0] NOP = 32'h00000013;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset = 1'b1;
  logic        id_ready = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_target = 32'h0;
  logic        sel = 1'b0;

  logic [31:0] imem [1024];

  logic [31:0] pc_a, instr_a, id_pc_a, id_instr_a, fault_pc_a;
  logic        id_valid_a, fetch_fault_a;
  logic [31:0] pc_b, instr_b, id_pc_b, id_instr_b, fault_pc_b;
  logic        id_valid_b, fetch_fault_b;

  assign instr_a = imem[pc_a[11:2]];
  assign instr_b = imem[pc_b[11:2]];

  instruction_fetch_unit u_dut_a (
    .clk(clk), .reset(reset), .pc(pc_a), .instruction(instr_a),
    .redirect_valid(redirect_valid), .redirect_target(redirect_target),
    .id_valid(id_valid_a), .id_ready(id_ready), .id_pc(id_pc_a),
    .id_instr(id_instr_a), .fetch_fault(fetch_fault_a), .fault_pc(fault_pc_a)
  );

  instruction_fetch_unit #(.RESET_PC(32'h00000FF8), .IMEM_WORDS(1024)) u_dut_b (
    .clk(clk), .reset(reset), .pc(pc_b), .instruction(instr_b),
    .redirect_valid(redirect_valid), .redirect_target(redirect_target),
    .id_valid(id_valid_b), .id_ready(id_ready), .id_pc(id_pc_b),
    .id_instr(id_instr_b), .fetch_fault(fetch_fault_b), .fault_pc(fault_pc_b)
  );

  logic [31:0] d_pc, d_id_pc, d_instr, d_fpc;
  logic        d_valid, d_fault;
  assign d_pc    = sel ? pc_b       : pc_a;
  assign d_id_pc = sel ? id_pc_b    : id_pc_a;
  assign d_instr = sel ? id_instr_b : id_instr_a;
  assign d_fpc   = sel ? fault_pc_b : fault_pc_a;
  assign d_valid = sel ? id_valid_b : id_valid_a;
  assign d_fault = sel ? fetch_fault_b : fetch_fault_a;

  int checks = 0;
  int failures = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %08h expected %08h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Behavioural reference: a queue of fetched {pc, word} pairs plus flags.
  bit          m_boot, m_halt, m_fault;
  logic [31:0] m_pc, m_fpc, m_reset_pc;
  logic [63:0] m_q[$];
  int          m_words = 1024;

  function automatic bit bad_addr(input logic [31:0] a);
    return (a[1:0] != 2'b00) || ((a >> 2) >= 32'(m_words));
  endfunction

  task automatic model_step();
    if (reset) begin
      m_boot = 1; m_halt = 0; m_fault = 0; m_fpc = 0;
      m_pc = m_reset_pc; m_q.delete();
    end else if (m_boot) begin
      m_boot = 0;
    end else if (!m_halt) begin
      if (redirect_valid) begin
        m_q.delete();
        if (bad_addr(redirect_target)) begin
          m_halt = 1; m_fault = 1; m_fpc = redirect_target;
        end else begin
          m_pc = redirect_target;
        end
      end else if ((m_pc >> 2) >= 32'(m_words)) begin
        m_q.delete();
        m_halt = 1; m_fault = 1; m_fpc = m_pc;
      end else begin
        if (m_q.size() > 0 && id_ready) void'(m_q.pop_front());
        if (m_q.size() < 2) begin
          m_q.push_back({m_pc, imem[m_pc[11:2]]});
          m_pc = m_pc + 32'd4;
        end
      end
    end
  endtask

  task automatic cmp_model();
    logic [63:0] head;
    bit          vld;
    vld  = (m_q.size() != 0);
    head = vld ? m_q[0] : {32'h0, NOP};
    check_val("m_pc", d_pc, m_pc);
    check_val("m_id_valid", 32'(d_valid), 32'(vld));
    check_val("m_id_pc", d_id_pc, head[63:32]);
    check_val("m_id_instr", d_instr, head[31:0]);
    check_val("m_fault", 32'(d_fault), 32'(m_fault));
    check_val("m_fault_pc", d_fpc, m_fpc);
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    cmp_model();
  endtask

  initial begin
    int r;
    for (int i = 0; i < 1024; i++) imem[i] = $urandom;
    imem[0] = 32'h00500113;
    imem[1] = 32'h00600193;
    imem[2] = 32'h002081b3;
    sel = 1'b0;
    m_reset_pc = 32'h0;

    // Free run
    reset = 1; id_ready = 1; tick();
    check_val("rst_valid", 32'(d_valid), 32'h0);
    check_val("rst_instr", d_instr, NOP);
    check_val("rst_id_pc", d_id_pc, 32'h0);
    check_val("rst_pc", d_pc, 32'h0);
    reset = 0; tick();
    check_val("boot_valid", 32'(d_valid), 32'h0);
    tick(); check_val("fr_pc0", d_id_pc, 32'h0); check_val("fr_i0", d_instr, 32'h00500113);
    tick(); check_val("fr_pc1", d_id_pc, 32'h4); check_val("fr_i1", d_instr, 32'h00600193);
    tick(); check_val("fr_pc2", d_id_pc, 32'h8); check_val("fr_i2", d_instr, 32'h002081b3);

    // Backpressure
    reset = 1; id_ready = 0; tick();
    reset = 0; tick();
    repeat (5) tick();
    check_val("bp_pc_hold", d_pc, 32'h8);
    check_val("bp_head", d_id_pc, 32'h0);
    id_ready = 1;
    tick(); check_val("bp_pc1", d_id_pc, 32'h4); check_val("bp_i1", d_instr, 32'h00600193);
    tick(); check_val("bp_pc2", d_id_pc, 32'h8); check_val("bp_i2", d_instr, 32'h002081b3);

    // Redirect with FIFO full
    id_ready = 0; tick();
    redirect_valid = 1; redirect_target = 32'h40; tick();
    redirect_valid = 0;
    check_val("rd_valid", 32'(d_valid), 32'h0);
    check_val("rd_pc", d_pc, 32'h40);
    tick();
    check_val("rd_id_pc", d_id_pc, 32'h40);
    check_val("rd_id_instr", d_instr, imem[16]);

    // Misaligned redirect, then ignored redirect
    redirect_valid = 1; redirect_target = 32'h42; tick();
    redirect_valid = 0;
    check_val("mis_fault", 32'(d_fault), 32'h1);
    check_val("mis_fpc", d_fpc, 32'h42);
    check_val("mis_valid", 32'(d_valid), 32'h0);
    redirect_valid = 1; redirect_target = 32'h0; tick();
    redirect_valid = 0; tick();
    check_val("halt_valid", 32'(d_valid), 32'h0);
    check_val("halt_pc", d_pc, 32'h44);
    check_val("halt_fpc", d_fpc, 32'h42);

    // Reset mid-operation with redirect asserted
    reset = 1; tick();
    reset = 0; tick(); tick(); tick();
    reset = 1; redirect_valid = 1; redirect_target = 32'h80; tick();
    check_val("mr_valid", 32'(d_valid), 32'h0);
    check_val("mr_pc", d_pc, 32'h0);
    check_val("mr_instr", d_instr, NOP);
    check_val("mr_fault", 32'(d_fault), 32'h0);
    reset = 0; redirect_valid = 0; id_ready = 1; tick(); tick();
    check_val("mr_first_pc", d_id_pc, 32'h0);
    check_val("mr_first_valid", 32'(d_valid), 32'h1);

    // Out-of-range sequential fetch on the second instance
    sel = 1; m_reset_pc = 32'h00000FF8;
    reset = 1; tick();
    reset = 0; tick(); tick();
    check_val("oor_pc0", d_id_pc, 32'hFF8); check_val("oor_i0", d_instr, imem[1022]);
    tick();
    check_val("oor_pc1", d_id_pc, 32'hFFC); check_val("oor_i1", d_instr, imem[1023]);
    tick();
    check_val("oor_fault", 32'(d_fault), 32'h1);
    check_val("oor_fpc", d_fpc, 32'h1000);
    check_val("oor_valid", 32'(d_valid), 32'h0);

    // Randomized traffic against the reference
    sel = 0; m_reset_pc = 32'h0;
    reset = 1; tick();
    reset = 0;
    repeat (800) begin
      id_ready       = ($urandom_range(0, 3) != 0);
      reset          = ($urandom_range(0, 39) == 0);
      redirect_valid = ($urandom_range(0, 14) == 0);
      r = $urandom_range(0, 9);
      if (r == 0)      redirect_target = $urandom;
      else if (r == 1) redirect_target = (32'($urandom_range(0, 1023)) << 2) | 32'h2;
      else if (r == 2) redirect_target = 32'($urandom_range(1016, 1023)) << 2;
      else             redirect_target = 32'($urandom_range(0, 1023)) << 2;
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/instruction_fetch_unit.md
INSTRUCTION_FETCH_UNIT -- requirements
Module: instruction_fetch_unit

Interface
REQ-001 The block SHALL have parameter RESET_PC, default 32'h00000000: first fetch address after reset.
REQ-002 The block SHALL have parameter IMEM_WORDS, default 1024: instruction memory depth in 32-bit words.
REQ-003 The block SHALL have parameter NOP_INSTR, default 32'h00000013: RV32 addi x0,x0,0.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-006 The block SHALL have port pc, output, 32 bits: fetch address driven to the instruction memory.
REQ-007 The block SHALL have port instruction, input, 32 bits: word returned combinationally by the instruction memory for pc.
REQ-008 The block SHALL have port redirect_valid, input, 1 bit: a branch or jump is resolved taken this cycle.
REQ-009 The block SHALL have port redirect_target, input, 32 bits: new fetch address.
REQ-010 The block SHALL have ports id_valid (output, 1 bit), id_ready (input, 1 bit), id_pc (output, 32 bits) and id_instr (output, 32 bits): the decode-stage valid/ready handshake.
REQ-011 The block SHALL have ports fetch_fault (output, 1 bit) and fault_pc (output, 32 bits): sticky fault flag and the offending address.

Function
REQ-012 The block SHALL implement an FSM with states BOOT, RUN and HALT; reset SHALL enter BOOT.
REQ-013 BOOT SHALL last exactly one cycle, with pc = RESET_PC and no push, then go to RUN.
REQ-014 In RUN, the block SHALL hold a 2-entry FIFO of {pc, instruction} pairs.
REQ-015 A push SHALL occur when the FIFO is not full, or when a pop occurs in the same cycle; on a push, the FIFO SHALL capture pc and instruction, and the pc register SHALL become pc+4, wrapping mod 2^32.
REQ-016 When the FIFO is full and no pop occurs, pc SHALL hold and no push SHALL occur (stall).
REQ-017 id_valid SHALL equal (count != 0); id_pc and id_instr SHALL be the FIFO head; a pop SHALL occur iff id_valid && id_ready.
REQ-018 A simultaneous push and pop SHALL keep count unchanged, and entries SHALL stay ordered.
REQ-019 Fetch-to-decode latency SHALL be one cycle: a word pushed at edge N appears on id_instr after edge N, when the FIFO was previously empty.
REQ-020 redirect_valid SHALL have highest priority in RUN: the FIFO SHALL be cleared (count=0), no push SHALL occur, pc SHALL become redirect_target, and any same-cycle pop SHALL be discarded.
REQ-021 If redirect_target[1:0] != 0, or redirect_target[31:2] >= IMEM_WORDS, the block SHALL instead enter HALT, set fetch_fault=1, set fault_pc=redirect_target, and clear the FIFO.
REQ-022 Sequential fetch reaching pc[31:2] >= IMEM_WORDS SHALL be treated as in REQ-021, with fault_pc = that pc and no push.
REQ-023 In HALT, id_valid SHALL be 0, pc SHALL hold, and redirect_valid SHALL be ignored; only reset SHALL exit HALT.
REQ-024 id_instr SHALL read NOP_INSTR whenever id_valid=0.

Reset
REQ-025 While reset=1 at an edge, the block SHALL set: state=BOOT, pc=RESET_PC, count=0, id_valid=0, id_pc=0, id_instr=NOP_INSTR, fetch_fault=0, fault_pc=0.
REQ-026 Reset SHALL override redirect_valid and handshake activity in the same cycle.
REQ-027 Reset asserted mid-stream SHALL discard all FIFO contents, and the first post-reset id_valid SHALL carry RESET_PC.

Structure
REQ-028 NOP_INSTR, FSM state encodings (BOOT/RUN/HALT) and the word width SHALL live in the shared CPU package.
REQ-029 The 2-entry FIFO SHALL be a sub-module named fetch_fifo, with ports clk, reset, clear, push, pop, din, dout, count.
REQ-030 pc SHALL be driven directly from the pc register, with no combinational path from instruction.

Verification
REQ-031 The bench SHALL cover free-run: reset, then id_ready=1 with imem[0..2] = 00500113, 00600193, 002081b3 -> after BOOT, id_pc = 0, 4, 8 on consecutive cycles, with matching id_instr.
REQ-032 The bench SHALL cover backpressure: id_ready=0 for 5 cycles -> count saturates at 2, pc holds at 8; then id_ready=1 -> id_pc 0, 4, 8 in order, with no loss or duplication.
REQ-033 The bench SHALL cover redirect: with the FIFO full, assert redirect_valid with target 0x40 -> next cycle id_valid=0, pc=0x40; the following cycle id_pc=0x40.
REQ-034 The bench SHALL cover misaligned redirect: redirect_target=0x42 -> fetch_fault=1, fault_pc=0x42, id_valid=0 permanently; a later redirect to 0x0 is ignored.
REQ-035 The bench SHALL cover out-of-range fetch: RESET_PC=0xFF8, IMEM_WORDS=1024 -> words 0xFF8 and 0xFFC are delivered, then fetch_fault=1 with fault_pc=0x1000.
REQ-036 The bench SHALL cover reset mid-operation: assert reset with count=2 and redirect_valid=1 -> all outputs at reset values; after release, first id_pc=RESET_PC.
